pipeline_sched_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Merges four stall/flush sources into one consistent set of per-stage Stall/Flush controls:
  - load-use stall request from the hazard unit;
  - taken branch resolved in EX;
  - multi-cycle MUL/DIV occupancy of EX;
  - data-memory wait states.
- Sits beside the forwarding/hazard unit and drives the pipeline registers and the PC mux.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/sat_counter32.sv | 25 ++
 rtl/pipeline_sched_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_sched_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
//   sched_state_e : scheduler FSM states (RUN, MDU_BUSY)
//   stage_ctrl_t  : packed per-stage stall/flush/redirect bundle
//   ST_* / FL_*   : bit positions inside stage_ctrl_t.stall / .flush
package pipe_ctrl_pkg;

  localparam int MDU_CNT_W  = 4;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [3:0] stall;     // [0]=IF [1]=ID [2]=EX [3]=MEM
    logic [3:0] flush;     // [0]=ID [1]=EX [2]=MEM [3]=WB
    logic       redirect;
  } stage_ctrl_t;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;

  localparam int FL_ID  = 0;
  localparam int FL_EX  = 1;
  localparam int FL_MEM = 2;
  localparam int FL_WB  = 3;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit saturating event counter with enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count this cycle
//   count : current count, sticks at 32'hFFFF_FFFF
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipeline_sched_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Merges data-memory wait states, multi-cycle MUL/DIV occupancy of EX,
// taken branches resolved in EX and load-use stalls into one coherent set of
// per-stage controls. Priority: mem-wait > MDU > branch > load-use.
//   inputs : clk, rst_n, load_stall, branch_taken_EX, mdu_start_EX,
//            dmem_req_MEM, dmem_ready
//   outputs: Stall_IF/ID/EX/MEM, Flush_ID/EX/MEM/WB, Redirect_IF (all
//            combinational), mdu_done (combinational), bus_err (sticky),
//            stall_cycles (saturating count of Stall_IF cycles)
module pipeline_sched_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_stall,
  input  logic        branch_taken_EX,
  input  logic        mdu_start_EX,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ready,
  output logic        Stall_IF,
  output logic        Stall_ID,
  output logic        Stall_EX,
  output logic        Stall_MEM,
  output logic        Flush_ID,
  output logic        Flush_EX,
  output logic        Flush_MEM,
  output logic        Flush_WB,
  output logic        Redirect_IF,
  output logic        mdu_done,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  localparam logic                  MDU_MULTI = (MDU_LAT >= 2);
  // Counter is loaded with the number of further stall cycles after the start cycle.
  localparam logic [MDU_CNT_W-1:0]  MDU_INIT  = MDU_CNT_W'((MDU_LAT >= 2) ? MDU_LAT - 2 : 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  sched_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   bus_err_d;
  stage_ctrl_t            ctrl;
  logic                   done;
  logic                   mem_pending;
  logic                   mem_wait;
  logic                   mem_timeout;

  assign mem_pending = dmem_req_MEM && !dmem_ready;
  assign mem_wait    = mem_pending && (wait_cnt_q < WAIT_LAST);
  // Last allowed wait cycle: pretend the access completed and flag the error.
  assign mem_timeout = mem_pending && (wait_cnt_q >= WAIT_LAST);

  always_comb begin
    ctrl       = '0;
    done       = 1'b0;
    state_d    = state_q;
    mdu_cnt_d  = mdu_cnt_q;
    wait_cnt_d = '0;
    bus_err_d  = bus_err_q_sticky();

    if (mem_wait) begin
      // Freeze everything up to MEM; EX/ID inputs are re-sampled on release.
      ctrl.stall         = 4'b1111;
      ctrl.flush[FL_WB]  = 1'b1;
      wait_cnt_d         = wait_cnt_q + 1'b1;
    end else begin
      if (mem_timeout) begin
        bus_err_d = 1'b1;
      end
      if (state_q == MDU_BUSY) begin
        if (mdu_cnt_q != '0) begin
          ctrl.stall[ST_IF]  = 1'b1;
          ctrl.stall[ST_ID]  = 1'b1;
          ctrl.stall[ST_EX]  = 1'b1;
          ctrl.flush[FL_MEM] = 1'b1;
          mdu_cnt_d          = mdu_cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = RUN;
        end
      end else if (mdu_start_EX) begin
        if (MDU_MULTI) begin
          ctrl.stall[ST_IF]  = 1'b1;
          ctrl.stall[ST_ID]  = 1'b1;
          ctrl.stall[ST_EX]  = 1'b1;
          ctrl.flush[FL_MEM] = 1'b1;
          mdu_cnt_d          = MDU_INIT;
          state_d            = MDU_BUSY;
        end else begin
          done = 1'b1;
        end
      end else if (branch_taken_EX) begin
        // Any concurrent load-use request belongs to a wrong-path ID instruction.
        ctrl.flush[FL_ID] = 1'b1;
        ctrl.flush[FL_EX] = 1'b1;
        ctrl.redirect     = 1'b1;
      end else if (load_stall) begin
        ctrl.stall[ST_IF] = 1'b1;
        ctrl.stall[ST_ID] = 1'b1;
        ctrl.flush[FL_EX] = 1'b1;
      end
    end

    // Outputs must be quiet while reset is held.
    if (!rst_n) begin
      ctrl = '0;
      done = 1'b0;
    end
  end

  function automatic logic bus_err_q_sticky();
    return bus_err;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      mdu_cnt_q  <= '0;
      wait_cnt_q <= '0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdu_cnt_q  <= mdu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err    <= bus_err_d;
    end
  end

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl.stall[ST_IF]),
    .count (stall_cycles)
  );

  assign Stall_IF    = ctrl.stall[ST_IF];
  assign Stall_ID    = ctrl.stall[ST_ID];
  assign Stall_EX    = ctrl.stall[ST_EX];
  assign Stall_MEM   = ctrl.stall[ST_MEM];
  assign Flush_ID    = ctrl.flush[FL_ID];
  assign Flush_EX    = ctrl.flush[FL_EX];
  assign Flush_MEM   = ctrl.flush[FL_MEM];
  assign Flush_WB    = ctrl.flush[FL_WB];
  assign Redirect_IF = ctrl.redirect;
  assign mdu_done    = done;

endmodule

// File: tb/tb_pipeline_sched_ctrl.sv
module tb_pipeline_sched_ctrl;

  localparam int LAT = 4;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_stall = 1'b0, branch_taken_EX = 1'b0, mdu_start_EX = 1'b0;
  logic        dmem_req_MEM = 1'b0, dmem_ready = 1'b0;
  logic        Stall_IF, Stall_ID, Stall_EX, Stall_MEM;
  logic        Flush_ID, Flush_EX, Flush_MEM, Flush_WB;
  logic        Redirect_IF, mdu_done, bus_err;
  logic [31:0] stall_cycles;

  pipeline_sched_ctrl #(.MDU_LAT(LAT), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_stall(load_stall), .branch_taken_EX(branch_taken_EX),
    .mdu_start_EX(mdu_start_EX), .dmem_req_MEM(dmem_req_MEM),
    .dmem_ready(dmem_ready),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Stall_EX(Stall_EX), .Stall_MEM(Stall_MEM),
    .Flush_ID(Flush_ID), .Flush_EX(Flush_EX), .Flush_MEM(Flush_MEM), .Flush_WB(Flush_WB),
    .Redirect_IF(Redirect_IF), .mdu_done(mdu_done), .bus_err(bus_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Output vector layout: {SIF,SID,SEX,SMEM, FID,FEX,FMEM,FWB, REDIR, DONE}
  localparam logic [9:0] O_NONE = 10'b0000_0000_0_0;
  localparam logic [9:0] O_MEMW = 10'b1111_0001_0_0;
  localparam logic [9:0] O_MDU  = 10'b1110_0010_0_0;
  localparam logic [9:0] O_DONE = 10'b0000_0000_0_1;
  localparam logic [9:0] O_BR   = 10'b0000_1100_1_0;
  localparam logic [9:0] O_LD   = 10'b1100_0100_0_0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles of EX occupancy still owed by a MUL/DIV
  // (0 = none), cycles already spent waiting on memory, sticky error,
  // and the running stall total.
  int      m_mdu_left;
  int      m_waited;
  bit      m_berr;
  longint  m_stalls;

  function automatic logic [9:0] outs();
    return {Stall_IF, Stall_ID, Stall_EX, Stall_MEM,
            Flush_ID, Flush_EX, Flush_MEM, Flush_WB, Redirect_IF, mdu_done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mdu_left = 0;
    m_waited   = 0;
    m_berr     = 1'b0;
    m_stalls   = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input bit lr, input bit br, input bit ms, input bit rq, input bit rd);
    logic [9:0] exp;
    @(negedge clk);
    rst_n = 1'b1;
    load_stall = lr; branch_taken_EX = br; mdu_start_EX = ms;
    dmem_req_MEM = rq; dmem_ready = rd;
    #1;
    check_eq("bus_err", 32'(bus_err), 32'(m_berr));
    check_eq("stall_cycles", stall_cycles, 32'(m_stalls));
    exp = O_NONE;
    if (rq && !rd && m_waited < TO - 1) begin
      exp = O_MEMW;
      m_waited++;
    end else begin
      if (rq && !rd) m_berr = 1'b1;
      m_waited = 0;
      if (m_mdu_left > 1) begin
        exp = O_MDU;
        m_mdu_left--;
      end else if (m_mdu_left == 1) begin
        exp = O_DONE;
        m_mdu_left = 0;
      end else if (ms) begin
        if (LAT == 1) exp = O_DONE;
        else begin
          exp = O_MDU;
          m_mdu_left = LAT - 1;
        end
      end else if (br) exp = O_BR;
      else if (lr) exp = O_LD;
    end
    check_eq("outs", 32'(outs()), 32'(exp));
    if (exp[9] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load_stall = 1'b0; branch_taken_EX = 1'b0; mdu_start_EX = 1'b0;
    dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
    #1;
    check_eq("rst_outs", 32'(outs()), 32'(O_NONE));
    check_eq("rst_stall_cycles", stall_cycles, 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    model_reset();
  endtask

  initial begin
    int acc_left;
    int sc0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // MUL/DIV pulse: three stall cycles then done.
    sc0 = int'(stall_cycles);
    cycle(0, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    check_eq("mdu_stall_total", stall_cycles - 32'(sc0), 32'd3);

    // Memory wait released by ready after five cycles.
    repeat (5) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    check_eq("wait_no_err", 32'(bus_err), 32'd0);

    // Branch with simultaneous load-use stall.
    cycle(1, 1, 0, 0, 0);
    // Branch and MDU start together: MDU wins.
    cycle(0, 1, 1, 0, 0);
    repeat (4) cycle(1, 1, 0, 0, 0);

    // Memory wait while MDU is one stall cycle from done.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Timeout: 63 stalled cycles, released on the 64th with the error flag.
    repeat (TO) cycle(0, 0, 0, 1, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);
    check_eq("timeout_err", 32'(bus_err), 32'd1);

    // Reset in the middle of an MDU operation.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Randomized traffic.
    acc_left = 0;
    for (int i = 0; i < 4000; i++) begin
      bit rq, rd;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        acc_left = 0;
      end
      if (acc_left == 0 && $urandom_range(0, 5) == 0)
        acc_left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(55, 80))
                                               : int'($urandom_range(1, 6));
      rq = (acc_left > 0);
      rd = (acc_left == 1);
      if (acc_left > 0) acc_left--;
      cycle(bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 5) == 0),
            bit'($urandom_range(0, 9) == 0), rq, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
